// File: rtl/pic_command_sequencer_if.sv
// +---------------------------------------------------------------------------+
// | pic_command_sequencer_if : CPU write bus and control outputs of the       |
// | 8259A command sequencer.                              Rev 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface pic_command_sequencer_if;
   logic       CS_n;
   logic       WR_n;
   logic       A0;
   logic [7:0] Din;
   logic [7:0] IMR;
   logic [1:0] Read_command;
   logic [4:0] vector_base;
   logic       single_mode;
   logic       ltim;
   logic [7:0] cascade_cfg;
   logic       aeoi;
   logic       upm;
   logic       init_done;
   logic       ocw2_valid;
   logic [2:0] ocw2_cmd;
   logic [2:0] ocw2_level;

   modport slave (
      input  CS_n, WR_n, A0, Din,
      output IMR, Read_command, vector_base, single_mode, ltim, cascade_cfg,
             aeoi, upm, init_done, ocw2_valid, ocw2_cmd, ocw2_level
   );

   modport master (
      output CS_n, WR_n, A0, Din,
      input  IMR, Read_command, vector_base, single_mode, ltim, cascade_cfg,
             aeoi, upm, init_done, ocw2_valid, ocw2_cmd, ocw2_level
   );
endinterface

`default_nettype wire

// File: rtl/pic_command_sequencer.sv
// +---------------------------------------------------------------------------+
// | pic_command_sequencer : 8259A ICW1..ICW4 init sequence and OCW1..3 decode. |
// |                                                       Rev 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

module pic_command_sequencer #(
   parameter logic [7:0] RESET_IMR   = 8'h00,
   parameter logic [1:0] RESET_RDCMD = 2'b10
) (
   input  wire logic                   clk,
   input  wire logic                   rst_n,
   pic_command_sequencer_if.slave      bus
);

   typedef enum logic [2:0] {
      S_UNINIT = 3'd0,
      S_ICW2   = 3'd1,
      S_ICW3   = 3'd2,
      S_ICW4   = 3'd3,
      S_READY  = 3'd4
   } state_t;

   state_t     r_state, w_state_nxt;
   logic       r_wr_d;
   logic       r_ic4;
   logic [7:0] r_imr;
   logic [1:0] r_rdcmd;
   logic [4:0] r_vector_base;
   logic       r_single_mode;
   logic       r_ltim;
   logic [7:0] r_cascade_cfg;
   logic       r_aeoi;
   logic       r_upm;
   logic       r_ocw2_valid;
   logic [2:0] r_ocw2_cmd;
   logic [2:0] r_ocw2_level;

   logic w_wr;
   logic w_ld_icw1, w_ld_icw2, w_ld_icw3, w_ld_icw4;
   logic w_ld_ocw1, w_ld_ocw2, w_ld_ocw3;

   // One accepted write per strobe: WR_n sampled low while it was high last cycle.
   assign w_wr = !bus.CS_n && !bus.WR_n && r_wr_d;

   always_comb begin
      w_state_nxt = r_state;
      w_ld_icw1   = 1'b0;
      w_ld_icw2   = 1'b0;
      w_ld_icw3   = 1'b0;
      w_ld_icw4   = 1'b0;
      w_ld_ocw1   = 1'b0;
      w_ld_ocw2   = 1'b0;
      w_ld_ocw3   = 1'b0;
      if (w_wr && !bus.A0 && bus.Din[4]) begin
         w_ld_icw1   = 1'b1;
         w_state_nxt = S_ICW2;
      end else if (w_wr) begin
         case (r_state)
            S_ICW2: if (bus.A0) begin
               w_ld_icw2 = 1'b1;
               if (!r_single_mode) w_state_nxt = S_ICW3;
               else if (r_ic4)     w_state_nxt = S_ICW4;
               else                w_state_nxt = S_READY;
            end
            S_ICW3: if (bus.A0) begin
               w_ld_icw3   = 1'b1;
               w_state_nxt = r_ic4 ? S_ICW4 : S_READY;
            end
            S_ICW4: if (bus.A0) begin
               w_ld_icw4   = 1'b1;
               w_state_nxt = S_READY;
            end
            S_READY: begin
               if (bus.A0)                        w_ld_ocw1 = 1'b1;
               else if (bus.Din[4:3] == 2'b00)    w_ld_ocw2 = 1'b1;
               else if (bus.Din[1])               w_ld_ocw3 = 1'b1;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_UNINIT;
         r_wr_d        <= 1'b1;
         r_ic4         <= 1'b0;
         r_imr         <= RESET_IMR;
         r_rdcmd       <= RESET_RDCMD;
         r_vector_base <= 5'd0;
         r_single_mode <= 1'b0;
         r_ltim        <= 1'b0;
         r_cascade_cfg <= 8'd0;
         r_aeoi        <= 1'b0;
         r_upm         <= 1'b0;
         r_ocw2_valid  <= 1'b0;
         r_ocw2_cmd    <= 3'd0;
         r_ocw2_level  <= 3'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_wr_d       <= bus.WR_n;
         r_ocw2_valid <= w_ld_ocw2;
         if (w_ld_icw1) begin
            r_ltim        <= bus.Din[3];
            r_single_mode <= bus.Din[1];
            r_ic4         <= bus.Din[0];
            r_imr         <= RESET_IMR;
            r_rdcmd       <= RESET_RDCMD;
            r_cascade_cfg <= 8'd0;
            r_aeoi        <= 1'b0;
            r_upm         <= 1'b0;
         end
         if (w_ld_icw2) r_vector_base <= bus.Din[7:3];
         if (w_ld_icw3) r_cascade_cfg <= bus.Din;
         if (w_ld_icw4) begin
            r_aeoi <= bus.Din[1];
            r_upm  <= bus.Din[0];
         end
         if (w_ld_ocw1) r_imr <= bus.Din;
         if (w_ld_ocw2) begin
            r_ocw2_cmd   <= bus.Din[7:5];
            r_ocw2_level <= bus.Din[2:0];
         end
         if (w_ld_ocw3) r_rdcmd <= bus.Din[1:0];
      end
   end

   assign bus.IMR          = r_imr;
   assign bus.Read_command = r_rdcmd;
   assign bus.vector_base  = r_vector_base;
   assign bus.single_mode  = r_single_mode;
   assign bus.ltim         = r_ltim;
   assign bus.cascade_cfg  = r_cascade_cfg;
   assign bus.aeoi         = r_aeoi;
   assign bus.upm          = r_upm;
   assign bus.init_done    = (r_state == S_READY);
   assign bus.ocw2_valid   = r_ocw2_valid;
   assign bus.ocw2_cmd     = r_ocw2_cmd;
   assign bus.ocw2_level   = r_ocw2_level;

endmodule

`default_nettype wire

// File: tb/tb_pic_command_sequencer.sv
// +---------------------------------------------------------------------------+
// | tb_pic_command_sequencer : directed vector bench for the 8259A sequencer. |
// |                                                       Rev 1.0             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_pic_command_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   pic_command_sequencer_if bus ();

   pic_command_sequencer #(
      .RESET_IMR   (8'h00),
      .RESET_RDCMD (2'b10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        cs_n;
      logic        a0;
      logic [7:0]  din;
      logic [34:0] exp;
   } vec_t;

   localparam int NVEC = 23;
   vec_t tbl [NVEC];
   int   n_vec   = 0;
   int   n_bad   = 0;
   int   n_pulse = 0;

   always @(posedge clk) if (bus.ocw2_valid === 1'b1) n_pulse++;

   // Packed view: {IMR, Read_command, vector_base, cascade_cfg,
   // {single,ltim,aeoi,upm,init_done}, ocw2_valid, ocw2_cmd, ocw2_level}
   function automatic logic [34:0] pk(input logic [7:0] imr, input logic [1:0] rd,
                                      input logic [4:0] vb, input logic [7:0] casc,
                                      input logic [4:0] fl, input logic v,
                                      input logic [2:0] c, input logic [2:0] l);
      return {imr, rd, vb, casc, fl, v, c, l};
   endfunction

   function automatic logic [34:0] obs();
      return pk(bus.IMR, bus.Read_command, bus.vector_base, bus.cascade_cfg,
                {bus.single_mode, bus.ltim, bus.aeoi, bus.upm, bus.init_done},
                bus.ocw2_valid, bus.ocw2_cmd, bus.ocw2_level);
   endfunction

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_write(input logic cs, input logic a0, input logic [7:0] din);
      @(negedge clk);
      bus.CS_n = cs;
      bus.A0   = a0;
      bus.Din  = din;
      bus.WR_n = 1'b0;
      @(negedge clk);
      bus.WR_n = 1'b1;
      bus.CS_n = 1'b1;
   endtask

   task automatic set(input int i, input logic cs, input logic a0, input logic [7:0] din,
                      input logic [7:0] imr, input logic [1:0] rd, input logic [4:0] vb,
                      input logic [7:0] casc, input logic [4:0] fl);
      tbl[i] = '{cs, a0, din, pk(imr, rd, vb, casc, fl, 1'b0, 3'd0, 3'd0)};
   endtask

   localparam logic [34:0] RST_VAL = {8'h00, 2'b10, 5'h00, 8'h00, 5'b00000, 1'b0, 3'd0, 3'd0};

   initial begin
      int p0;
      bus.CS_n = 1'b1;
      bus.WR_n = 1'b1;
      bus.A0   = 1'b0;
      bus.Din  = 8'h00;

      //      idx cs a0 din    IMR    RD     VB     CASC   {S,L,A,U,I}
      set( 0, 0, 1, 8'hFF, 8'h00, 2'b10, 5'h00, 8'h00, 5'b00000); // pre-init OCW1 ignored
      set( 1, 0, 0, 8'h0B, 8'h00, 2'b10, 5'h00, 8'h00, 5'b00000); // pre-init OCW3 ignored
      set( 2, 0, 0, 8'h13, 8'h00, 2'b10, 5'h00, 8'h00, 5'b10000); // ICW1 SNGL IC4
      set( 3, 0, 1, 8'h40, 8'h00, 2'b10, 5'h08, 8'h00, 5'b10000); // ICW2 -> ICW4
      set( 4, 0, 1, 8'h03, 8'h00, 2'b10, 5'h08, 8'h00, 5'b10111); // ICW4 -> READY
      set( 5, 0, 0, 8'h0B, 8'h00, 2'b11, 5'h08, 8'h00, 5'b10111); // OCW3 ISR
      set( 6, 0, 0, 8'h0A, 8'h00, 2'b10, 5'h08, 8'h00, 5'b10111); // OCW3 IRR
      set( 7, 0, 0, 8'h0B, 8'h00, 2'b11, 5'h08, 8'h00, 5'b10111);
      set( 8, 0, 0, 8'h08, 8'h00, 2'b11, 5'h08, 8'h00, 5'b10111); // RR=0: unchanged
      set( 9, 0, 1, 8'hAA, 8'hAA, 2'b11, 5'h08, 8'h00, 5'b10111); // OCW1
      set(10, 1, 1, 8'h55, 8'hAA, 2'b11, 5'h08, 8'h00, 5'b10111); // CS_n high
      set(11, 1, 0, 8'h13, 8'hAA, 2'b11, 5'h08, 8'h00, 5'b10111); // CS_n high ICW1
      set(12, 0, 0, 8'h18, 8'h00, 2'b10, 5'h08, 8'h00, 5'b01000); // ICW1 LTIM cascade
      set(13, 0, 0, 8'h04, 8'h00, 2'b10, 5'h08, 8'h00, 5'b01000); // A0=0 in ICW2 ignored
      set(14, 0, 1, 8'h20, 8'h00, 2'b10, 5'h04, 8'h00, 5'b01000); // ICW2 -> ICW3
      set(15, 0, 1, 8'h04, 8'h00, 2'b10, 5'h04, 8'h04, 5'b01001); // ICW3 -> READY
      set(16, 0, 1, 8'hAA, 8'hAA, 2'b10, 5'h04, 8'h04, 5'b01001); // OCW1
      set(17, 0, 0, 8'h0B, 8'hAA, 2'b11, 5'h04, 8'h04, 5'b01001);
      set(18, 0, 0, 8'h11, 8'h00, 2'b10, 5'h04, 8'h00, 5'b00000); // ICW1 cascade IC4
      set(19, 0, 1, 8'h48, 8'h00, 2'b10, 5'h09, 8'h00, 5'b00000); // ICW2 -> ICW3
      set(20, 0, 0, 8'h13, 8'h00, 2'b10, 5'h09, 8'h00, 5'b10000); // restart mid-sequence
      set(21, 0, 1, 8'h50, 8'h00, 2'b10, 5'h0A, 8'h00, 5'b10000); // ICW2 -> ICW4
      set(22, 0, 1, 8'h00, 8'h00, 2'b10, 5'h0A, 8'h00, 5'b10001); // ICW4 -> READY

      repeat (2) @(negedge clk);
      check("reset_state", obs(), RST_VAL);
      rst_n = 1'b1;
      @(negedge clk);
      check("after_reset_release", obs(), RST_VAL);

      for (int i = 0; i < NVEC; i++) begin
         do_write(tbl[i].cs_n, tbl[i].a0, tbl[i].din);
         check($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // OCW2 with WR_n held low for five cycles: a single pulse
      p0 = n_pulse;
      @(negedge clk);
      bus.CS_n = 1'b0;
      bus.A0   = 1'b0;
      bus.Din  = 8'h63;
      bus.WR_n = 1'b0;
      @(negedge clk);
      check("ocw2_pulse", obs(), pk(8'h00, 2'b10, 5'h0A, 8'h00, 5'b10001, 1'b1, 3'b011, 3'b011));
      @(negedge clk);
      check("ocw2_pulse_end", obs(), pk(8'h00, 2'b10, 5'h0A, 8'h00, 5'b10001, 1'b0, 3'b011, 3'b011));
      repeat (3) @(negedge clk);
      bus.WR_n = 1'b1;
      bus.CS_n = 1'b1;
      @(negedge clk);
      check("ocw2_pulse_count", 35'(n_pulse - p0), 35'd1);
      check("ocw2_hold", obs(), pk(8'h00, 2'b10, 5'h0A, 8'h00, 5'b10001, 1'b0, 3'b011, 3'b011));

      do_write(1'b0, 1'b0, 8'hE5);
      check("ocw2_second", obs(), pk(8'h00, 2'b10, 5'h0A, 8'h00, 5'b10001, 1'b1, 3'b111, 3'b101));

      // Reset asserted while an OCW2 pulse is pending
      do_write(1'b0, 1'b0, 8'h20);
      #2 rst_n = 1'b0;
      #1 check("reset_clears_pulse", obs(), RST_VAL);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset asserted mid-ICW3
      do_write(1'b0, 1'b0, 8'h10);
      do_write(1'b0, 1'b1, 8'h20);
      check("in_icw3", obs(), pk(8'h00, 2'b10, 5'h04, 8'h00, 5'b00000, 1'b0, 3'd0, 3'd0));
      #2 rst_n = 1'b0;
      #1 check("async_reset_mid_icw3", obs(), RST_VAL);
      @(negedge clk);
      rst_n = 1'b1;
      do_write(1'b0, 1'b1, 8'h77);
      check("uninit_after_reset", obs(), RST_VAL);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pic_command_sequencer.md
Name: pic_command_sequencer

Overview:
- Control-word sequencer for the 8259A PIC. Decodes CPU writes (CS_n, WR_n, A0, D) through the ICW1→ICW4 initialization sequence and then handles OCW1/OCW2/OCW3.
- Supplies IMR and Read_command to the read/write logic, and the vector base, mode bits and EOI commands to the priority/ISR logic.
- All inputs are treated as synchronous to clk.

Parameters:
- RESET_IMR, 8'h00, IMR value on reset and after ICW1.
- RESET_RDCMD, 2'b10, Read_command value on reset and after ICW1 (2'b10 = read IRR).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- CS_n  input  1  chip select, active low
- WR_n  input  1  write strobe, active low
- A0  input  1  address bit
- Din  input  8  CPU write data
- IMR  output  8  interrupt mask register
- Read_command  output  2  RR/RIS bits (10 = IRR, 11 = ISR)
- vector_base  output  5  T7..T3 from ICW2
- single_mode  output  1  SNGL from ICW1
- ltim  output  1  level-triggered mode from ICW1
- cascade_cfg  output  8  ICW3 contents
- aeoi  output  1  auto-EOI from ICW4
- upm  output  1  8086 mode from ICW4
- init_done  output  1  high in READY
- ocw2_valid  output  1  one-cycle pulse on an OCW2 write
- ocw2_cmd  output  3  R,SL,EOI (D7..D5), valid with ocw2_valid
- ocw2_level  output  3  L2..L0 (D2..D0), valid with ocw2_valid

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=UNINIT
  - IMR=RESET_IMR, Read_command=RESET_RDCMD
  - vector_base, cascade_cfg, single_mode, ltim, aeoi, upm, init_done, ocw2_valid, ocw2_cmd, ocw2_level all 0
  - IC4 internal flag = 0
  - wr_d (WR_n history) reset to 1
- Write detect:
  - A write is accepted on the clk edge where CS_n=0, WR_n=0 and wr_d=1 (WR_n falling, sampled).
  - Din and A0 are sampled on that same edge.
  - Exactly one write per strobe, however long WR_n stays low.
  - WR_n with CS_n=1 is ignored; wr_d still tracks WR_n.
- ICW1 (A0=0, Din[4]=1): accepted in any state, including mid-sequence (restarts it).
  - Stores ltim=Din[3], single_mode=Din[1], IC4=Din[0].
  - IMR←RESET_IMR, Read_command←RESET_RDCMD, cascade_cfg←0, aeoi←0, upm←0.
  - init_done←0, state←ICW2.
- States (all transitions take effect on the accepting edge):
  - UNINIT: only ICW1 is accepted; all other writes are ignored.
  - ICW2 (A0=1): vector_base←Din[7:3]. Next state ICW3 if single_mode=0, else ICW4 if IC4=1, else READY.
  - ICW3 (A0=1): cascade_cfg←Din. Next state ICW4 if IC4=1, else READY.
  - ICW4 (A0=1): aeoi←Din[1], upm←Din[0]; next state READY.
  - In ICW2/ICW3/ICW4, a write with A0=0 and Din[4]=0 is ignored and the state is held.
  - READY: init_done=1.
    - A0=1: OCW1, IMR←Din.
    - A0=0, Din[4:3]=00: OCW2. ocw2_valid=1 for exactly the next cycle; ocw2_cmd=Din[7:5], ocw2_level=Din[2:0].
    - A0=0, Din[4:3]=01: OCW3. If Din[1]=1, Read_command←Din[1:0]; otherwise Read_command is unchanged. Din[6:5] (special mask) and Din[2] (poll) are ignored in this block.
- ocw2_cmd and ocw2_level hold their last values when ocw2_valid=0.
- Latency: every register update is visible one clk after the accepting edge. No back-pressure.
- Reset asserted mid-sequence: immediate return to UNINIT with all reset values; any pending ocw2_valid is cleared.

Test Plan:
- Reset, then ICW1=8'h13 (SNGL=1, IC4=1), ICW2=8'h40, ICW4=8'h03 → vector_base=5'h08, ICW3 skipped, aeoi=1, upm=1, init_done=1 after the third write, IMR=8'h00, Read_command=2'b10.
- ICW1=8'h10 (cascade, no IC4), ICW2=8'h20, ICW3=8'h04 → cascade_cfg=8'h04, state READY after ICW3, aeoi=0; ICW4-style write A0=1 Din=8'hAA then sets IMR=8'hAA (OCW1).
- In READY, write OCW3 A0=0 Din=8'h0B → Read_command=2'b11. Then Din=8'h0A → 2'b10. Then Din=8'h08 → stays 2'b10.
- In READY, write OCW2 A0=0 Din=8'h63 → ocw2_valid high exactly 1 cycle, ocw2_cmd=3'b011, ocw2_level=3'b011. Hold WR_n low 5 cycles → still only one pulse.
- Before ICW1: A0=1 Din=8'hFF and OCW3 writes → IMR=8'h00, Read_command=2'b10, init_done=0. Writes with CS_n=1 in READY → no change.
- After ICW2, issue ICW1=8'h13 again (restart) → state ICW2, IMR reset. Assert rst_n=0 mid-ICW3 → all outputs return to reset values asynchronously.
